mont_exp_ctrl: RTL and testbench

MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

---
 rtl/mont_exp_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_exp_ctrl.sv
// -----------------------------------------------------------------------------
// mont_exp_ctrl
//
// Sequencer for modular exponentiation by left-to-right square-and-multiply in
// the Montgomery domain. The block contains no arithmetic. It walks the
// exponent from its most significant set bit down to bit 0. For each step it
// issues one operation to an external memory-mapped Montgomery multiplier. The
// accumulator lives in memory at res_addr and is updated in place.
//
// Operation sequence for exponent e whose top set bit is m:
//   first : res = one  * base      (res = one * one when e == 0)
//   then for each bit i from m-1 down to 0:
//           res = res * res        (square)
//           res = res * base       (multiply, only when e[i] == 1)
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   start              job request, accepted only while idle
//   exp                exponent, latched on an accepted start
//   base_addr          operand address, latched on an accepted start
//   one_addr           address of R mod N (Montgomery one), latched on start
//   n_addr             modulus address, latched on an accepted start
//   res_addr           result/accumulator address, latched on an accepted start
//   busy               high whenever a job is in progress
//   done               one-cycle pulse once the result sits at res_addr
//   op_count           multiplier operations completed in the current/last job
//   mm_start           two-cycle start request to the multiplier
//   mm_A_addr/mm_B_addr  operand addresses of the current operation
//   mm_N_addr          modulus address of the current operation
//   mm_res_addr        result address of the current operation
//   mm_done            multiplier completion pulse
// -----------------------------------------------------------------------------
module mont_exp_ctrl #(
  parameter int EXP_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [EXP_BITS-1:0] exp,
  input  logic [31:0]         base_addr,
  input  logic [31:0]         one_addr,
  input  logic [31:0]         n_addr,
  input  logic [31:0]         res_addr,
  output logic                busy,
  output logic                done,
  output logic [15:0]         op_count,
  output logic                mm_start,
  output logic [31:0]         mm_A_addr,
  output logic [31:0]         mm_B_addr,
  output logic [31:0]         mm_N_addr,
  output logic [31:0]         mm_res_addr,
  input  logic                mm_done
);

  localparam int IDX_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE1,
    S_ISSUE2,
    S_WAIT,
    S_FIN
  } state_t;

  // OP_NONE marks a job whose first operation has not been selected yet.
  // It plays the role of a cleared "first" flag.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_FIRST,
    OP_SQR,
    OP_MUL
  } op_t;

  state_t state_q, state_d;
  op_t    op_q, op_d;

  logic [EXP_BITS-1:0] exp_q;
  logic [31:0]         base_q, one_q, n_q, res_q;
  logic [IDX_W-1:0]    idx_q;
  logic [15:0]         op_count_q;
  logic [31:0]         a_q, b_q, nn_q, r_q;

  // Control strobes from the next-state logic into the datapath registers.
  logic       load_job;
  logic       idx_dec;
  logic       issue;
  logic       count_inc;
  logic [31:0] a_d, b_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and step selection
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default before the case. A path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    load_job  = 1'b0;
    idx_dec   = 1'b0;
    issue     = 1'b0;
    count_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_job = 1'b1;
          state_d  = S_SCAN;
        end
      end

      // Skip leading zeros one bit per cycle. Bit 0 is always reached, so an
      // all-zero exponent still produces its single one*one operation.
      S_SCAN: begin
        if (!exp_q[idx_q] && (idx_q != '0)) begin
          idx_dec = 1'b1;
        end else begin
          issue   = 1'b1;
          op_d    = OP_FIRST;
          state_d = S_ISSUE1;
        end
      end

      S_ISSUE1: state_d = S_ISSUE2;
      S_ISSUE2: state_d = S_WAIT;

      S_WAIT: begin
        if (mm_done) begin
          count_inc = 1'b1;
          // A square on a set bit is followed by a multiply at the same
          // index. Every other step moves down one bit or finishes.
          if ((op_q == OP_SQR) && exp_q[idx_q]) begin
            issue   = 1'b1;
            op_d    = OP_MUL;
            state_d = S_ISSUE1;
          end else if (idx_q == '0) begin
            state_d = S_FIN;
          end else begin
            idx_dec = 1'b1;
            issue   = 1'b1;
            op_d    = OP_SQR;
            state_d = S_ISSUE1;
          end
        end
      end

      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand selection for the operation being issued. A square on the
  // accumulator is the default. The multiplier tolerates A or B aliasing res.
  always_comb begin
    a_d = res_q;
    b_d = res_q;
    case (op_d)
      OP_FIRST: begin
        a_d = one_q;
        b_d = exp_q[idx_q] ? base_q : one_q;
      end
      OP_MUL:  b_d = base_q;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= '0;
      base_q     <= '0;
      one_q      <= '0;
      n_q        <= '0;
      res_q      <= '0;
      idx_q      <= '0;
      op_q       <= OP_NONE;
      op_count_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      nn_q       <= '0;
      r_q        <= '0;
    end else begin
      if (load_job) begin
        exp_q      <= exp;
        base_q     <= base_addr;
        one_q      <= one_addr;
        n_q        <= n_addr;
        res_q      <= res_addr;
        idx_q      <= IDX_TOP;
        op_q       <= OP_NONE;
        op_count_q <= '0;
      end else begin
        if (idx_dec) begin
          idx_q <= idx_q - 1'b1;
        end
        // The multiplier addresses load only when a new operation is
        // selected. This keeps them frozen from ISSUE1 until the completing
        // mm_done.
        if (issue) begin
          op_q <= op_d;
          a_q  <= a_d;
          b_q  <= b_d;
          nn_q <= n_q;
          r_q  <= res_q;
        end
        if (count_inc && (op_count_q != 16'hFFFF)) begin
          op_count_q <= op_count_q + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_FIN);
    mm_start = (state_q == S_ISSUE1) || (state_q == S_ISSUE2);
  end

  assign op_count    = op_count_q;
  assign mm_A_addr   = a_q;
  assign mm_B_addr   = b_q;
  assign mm_N_addr   = nn_q;
  assign mm_res_addr = r_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mont_exp_ctrl
//
// Self-checking bench for mont_exp_ctrl. A memory-mapped multiplier model
// computes A*B mod N. One is stored as 1, so R = 1 and the result is plain
// modular arithmetic. The expected operation list is built from the bits of
// the exponent. The expected result comes from an independent right-to-left
// modular power.
// -----------------------------------------------------------------------------
module tb_mont_exp_ctrl;

  localparam int EXP_BITS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] exp_in = '0;
  logic [31:0] base_addr = '0, one_addr = '0, n_addr = '0, res_addr = '0;
  logic        busy, done, mm_start;
  logic        mm_done = 1'b0;
  logic [15:0] op_count;
  logic [31:0] mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.EXP_BITS(EXP_BITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .exp         (exp_in),
    .base_addr   (base_addr),
    .one_addr    (one_addr),
    .n_addr      (n_addr),
    .res_addr    (res_addr),
    .busy        (busy),
    .done        (done),
    .op_count    (op_count),
    .mm_start    (mm_start),
    .mm_A_addr   (mm_A_addr),
    .mm_B_addr   (mm_B_addr),
    .mm_N_addr   (mm_N_addr),
    .mm_res_addr (mm_res_addr),
    .mm_done     (mm_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory image shared by the stimulus and the multiplier model.
  logic [63:0] mem [logic [31:0]];

  // Expected job: operation list {A,B}, N/res addresses, count, result.
  logic [63:0] exp_ops[$];
  logic [31:0] job_n, job_res;
  int          exp_total;
  int          exp_skips;
  logic [63:0] exp_result;
  bit          done_seen = 0;
  bit          stray_req = 0;
  time         accept_t = 0;
  time         first_t = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference modular power, computed right-to-left.
  function automatic logic [63:0] ref_pow(input logic [63:0] b, input logic [31:0] e,
                                          input logic [63:0] n);
    logic [63:0] r = 64'd1 % n;
    logic [63:0] x = b % n;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % n;
      x = (x * x) % n;
    end
    return r;
  endfunction

  // Build the expected operation list from the exponent bits.
  task automatic plan_job(input logic [31:0] e);
    int msb = -1;
    exp_ops.delete();
    for (int i = 0; i < 32; i++) if (e[i]) msb = i;
    if (msb < 0) begin
      exp_ops.push_back({one_addr, one_addr});
      exp_skips = EXP_BITS - 1;
    end else begin
      exp_ops.push_back({one_addr, base_addr});
      for (int i = msb - 1; i >= 0; i--) begin
        exp_ops.push_back({res_addr, res_addr});
        if (e[i]) exp_ops.push_back({res_addr, base_addr});
      end
      exp_skips = EXP_BITS - 1 - msb;
    end
    exp_total = exp_ops.size();
  endtask

  // ---------------------------------------------------------------------------
  // Multiplier model: sample A/B in the first start cycle and N/res in the
  // second. Complete after a random latency.
  // ---------------------------------------------------------------------------
  int          mm_st = 0;
  int          lat = 0;
  logic [31:0] cap_a, cap_b, cap_n, cap_r;
  logic [63:0] want;

  initial forever begin
    @(negedge clk);
    mm_done = 1'b0;
    if (!rst_n) begin
      mm_st = 0;
    end else begin
      case (mm_st)
        0: begin
          if (mm_start) begin
            cap_a = mm_A_addr;
            cap_b = mm_B_addr;
            if (first_t == 0) first_t = $time;
            mm_st = 1;
          end else if (stray_req) begin
            mm_done   = 1'b1;
            stray_req = 0;
          end
        end
        1: begin
          check("mm_start_second_cycle", mm_start, 1);
          check("ab_stable_issue2", {cap_a, cap_b}, {mm_A_addr, mm_B_addr});
          cap_n = mm_N_addr;
          cap_r = mm_res_addr;
          lat   = $urandom_range(0, 5);
          mm_st = 2;
        end
        default: begin
          check("mm_start_low_in_wait", mm_start, 0);
          check("addr_stable_wait", {cap_a, cap_b, cap_n, cap_r},
                {mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr});
          if (lat == 0) begin
            if (exp_ops.size() == 0) begin
              check("op_unexpected", 1, 0);
            end else begin
              want = exp_ops.pop_front();
              check("op_addrs", {cap_a, cap_b, cap_n, cap_r}, {want, job_n, job_res});
            end
            mem[cap_r] = (mem[cap_a] * mem[cap_b]) % mem[cap_n];
            mm_done    = 1'b1;
            mm_st      = 0;
          end else begin
            lat--;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Completion monitor
  // ---------------------------------------------------------------------------
  bit prev_done = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_done = 0;
    end else begin
      if (done) begin
        check("done_single_cycle", prev_done, 0);
        check("busy_with_done", busy, 1);
        check("op_count_at_done", op_count, exp_total);
        check("result", mem[job_res], exp_result);
        check("ops_all_issued", exp_ops.size(), 0);
        check("scan_cycles", ((first_t - accept_t) - 5) / 10, exp_skips + 1);
        done_seen = 1;
      end
      prev_done = done;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic setup_job(input logic [31:0] e, input logic [63:0] bval, input logic [63:0] nval);
    logic [31:0] r = $urandom & 32'h0FFF_FF00;
    base_addr = r;
    one_addr  = r + 32'd8;
    n_addr    = r + 32'd16;
    res_addr  = r + 32'd24;
    job_n     = n_addr;
    job_res   = res_addr;
    mem[base_addr] = bval;
    mem[one_addr]  = 64'd1;
    mem[n_addr]    = nval;
    mem[res_addr]  = 64'hDEAD;
    exp_result = ref_pow(bval, e, nval);
    plan_job(e);
    done_seen = 0;
    first_t   = 0;
    exp_in    = e;
  endtask

  task automatic fire_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    accept_t = $time;
    #1 start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_job(input logic [31:0] e, input logic [63:0] bval, input logic [63:0] nval,
                         input bit poke, output int cnt, output logic [63:0] res);
    setup_job(e, bval, nval);
    fire_start();
    if (poke) begin
      // A start while busy, with different operands, must be ignored.
      repeat (2) @(posedge clk);
      #1;
      start     = 1'b1;
      exp_in    = ~e;
      base_addr = 32'hBAD0_0000;
      res_addr  = 32'hBAD0_0008;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int c = 0; c < 20000 && !done_seen; c++) @(negedge clk);
    if (!done_seen) check("job_timeout", 0, 1);
    @(posedge clk);
    #1;
    check("idle_after_done", busy, 0);
    cnt = op_count;
    res = mem[job_res];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [63:0] res;
    logic [31:0] e, t, nval;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, mm_start, op_count, mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done, mm_start, op_count}, 0);

    // exp = 0: one operation, one*one.
    run_job(32'd0, 64'd7, 64'd1000003, 1'b0, cnt, res);
    check("exp0_op_count", cnt, 1);
    check("exp0_result", res, 1);

    // exp = 5: mul, sqr, sqr, mul. 2^5 mod p = 32.
    run_job(32'd5, 64'd2, 64'd1000003, 1'b1, cnt, res);
    check("exp5_op_count", cnt, 4);
    check("exp5_result", res, 32);

    // A stray mm_done while idle must not change anything.
    @(posedge clk);
    #1 stray_req = 1;
    repeat (3) @(posedge clk);
    #1;
    check("stray_done_op_count", op_count, 4);
    check("stray_done_idle", busy, 0);

    // Top bit only: no skip cycles, 32 operations.
    run_job(32'h8000_0000, 64'd3, 64'd1000003, 1'b1, cnt, res);
    check("msb_op_count", cnt, 32);

    // Reset during WAIT of an exp = 7 job.
    setup_job(32'd7, 64'd5, 64'd1000003);
    fire_start();
    for (int c = 0; c < 2000 && mm_st != 2; c++) @(negedge clk);
    check("reached_wait", mm_st, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, mm_start, op_count, mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr}, 0);
    repeat (3) @(negedge clk);
    exp_ops.delete();
    done_seen = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_resume_after_reset", {busy, mm_start}, 0);

    run_job(32'd1, 64'd11, 64'd1000003, 1'b0, cnt, res);
    check("exp1_op_count", cnt, 1);
    check("exp1_result", res, 11);

    // Randomized jobs.
    for (int j = 0; j < 20; j++) begin
      t = $urandom;
      case ($urandom_range(0, 3))
        0: e = t;
        1: e = t & 32'hF;
        2: e = 32'd1 << (t % 32);
        default: e = t | 32'h8000_0000;
      endcase
      t    = $urandom;
      nval = (t & 32'h7FFF_FFFF) | 32'h3;
      run_job(e, 64'($urandom % nval), 64'(nval), 1'($urandom_range(0, 1)), cnt, res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
